mem_arbiter: RTL

Single-port memory arbiter shared by the instruction-fetch requester (IFU) and the load/store requester (MEM stage). Sits between the two pipeline requesters and the one memory bus. Sequences one outstanding bus transaction at a time, routes responses back to the owner, and drives per-requester stall flags into the pipeline stall controller. Load/store has priority, with a bounded-starvation guarantee for fetch.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_prio.sv | 42 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int STREAK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Grant decision between fetch and load/store, with a saturating LS streak
// counter that hands the bus to a waiting fetch after STREAK_MAX LS grants.
module mem_arbiter_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req_valid,
  input  logic if_flush,
  input  logic ls_req_valid,
  output logic if_grant,
  output logic ls_grant
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  logic [SW-1:0] streak;
  logic          if_elig;
  logic          if_turn;

  // A fetch being redirected this cycle cannot win, even when it is owed a turn.
  always_comb begin
    if_elig  = if_req_valid & ~if_flush;
    if_turn  = if_elig & (streak == SW'(STREAK_MAX));
    ls_grant = arb_en & ls_req_valid & ~if_turn;
    if_grant = arb_en & if_elig & ~ls_grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (if_grant) begin
      streak <= '0;
    end else if (ls_grant && if_req_valid && (streak != SW'(STREAK_MAX))) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory bus arbiter for fetch and load/store requesters:
// latches the winning request, sequences REQ/RESP, routes the response back.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                if_stall,
  output logic                ls_stall
);

  state_t state, state_nxt;
  owner_t owner;
  logic   drop;
  logic   arb_en, if_grant, ls_grant;
  logic   busy, rsp_take, if_kill;

  mem_arbiter_prio #(.STREAK_MAX(STREAK_MAX)) u_prio (
    .clk          (clk),
    .rst          (rst),
    .arb_en       (arb_en),
    .if_req_valid (if_req_valid),
    .if_flush     (if_flush),
    .ls_req_valid (ls_req_valid),
    .if_grant     (if_grant),
    .ls_grant     (ls_grant)
  );

  assign arb_en   = (state == IDLE);
  assign busy     = (state != IDLE);
  assign rsp_take = (state == RESP) & mem_rsp_valid;
  // A flush in the response cycle itself also suppresses the fetch response.
  assign if_kill  = drop | if_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_grant || ls_grant) state_nxt = REQ;
      REQ:     if (mem_req_ready)        state_nxt = RESP;
      RESP:    if (mem_rsp_valid)        state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Ready/stall are combinational on requester inputs; hold them low while in reset.
  assign if_req_ready  = rst & if_grant;
  assign ls_req_ready  = rst & ls_grant;
  assign mem_req_valid = (state == REQ);
  assign if_stall = rst & ((if_req_valid & ~if_grant) | (busy & (owner == OWN_IF) & ~drop));
  assign ls_stall = rst & ((ls_req_valid & ~ls_grant) | (busy & (owner == OWN_LS)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_IF;
      drop      <= 1'b0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (ls_grant) begin
      owner     <= OWN_LS;
      drop      <= 1'b0;
      mem_addr  <= ls_addr;
      mem_wen   <= ls_wen;
      mem_wdata <= ls_wdata;
      mem_wmask <= ls_wmask;
    end else if (if_grant) begin
      owner     <= OWN_IF;
      drop      <= 1'b0;
      mem_addr  <= if_addr;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (busy && (owner == OWN_IF) && if_flush) begin
      drop      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
    end else begin
      if_rsp_valid <= rsp_take & (owner == OWN_IF) & ~if_kill;
      ls_rsp_valid <= rsp_take & (owner == OWN_LS);
      if (rsp_take && (owner == OWN_IF) && !if_kill) if_rdata <= mem_rdata;
      if (rsp_take && (owner == OWN_LS) && !mem_wen) ls_rdata <= mem_rdata;
    end
  end

endmodule
